// File: rtl/mbldcm_pkg.sv
// Shared types for the BLDC dead-time generator: per-channel FSM encoding and a
// constant clog2 helper used to size the state register.
package mbldcm_pkg;

    function automatic int mbldcm_clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    localparam int STATE_W = mbldcm_clog2(5);

    typedef enum logic [STATE_W-1:0] {
        ST_OFF    = 3'd0,
        ST_DEAD_H = 3'd1,
        ST_HIGH   = 3'd2,
        ST_DEAD_L = 3'd3,
        ST_LOW    = 3'd4
    } dt_state_e;

endpackage

// File: rtl/mbldcm_dead_time_ch.sv
// One half-bridge leg: request decode, dead-time down-counter and registered
// complementary gate enables, with a force-off input from the fault latch.
//
// state   | meaning
// OFF     | both switches off, no request
// DEAD_H  | counting dead interval before turning high side on
// HIGH    | high-side gate enabled
// DEAD_L  | counting dead interval before turning low side on
// LOW     | low-side gate enabled
module mbldcm_dead_time_ch
    import mbldcm_pkg::*;
#(
    parameter int pWidthDelay = 8
) (
    input  logic                   iClock,
    input  logic                   iReset_n,
    input  logic                   iForceOff,
    input  logic [pWidthDelay-1:0] iDeadTime,
    input  logic                   iActive,
    input  logic                   iPhase,
    output logic                   oHigh,
    output logic                   oLow
);

    dt_state_e              state_q, state_d;
    logic [pWidthDelay-1:0] cnt_q, cnt_d;
    logic                   high_q, high_d;
    logic                   low_q, low_d;
    logic                   req_h, req_l;

    assign req_h = iActive & iPhase;
    assign req_l = iActive & ~iPhase;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (iForceOff) begin
            state_d = ST_OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (req_h) begin
                        state_d = ST_DEAD_H;
                        cnt_d   = iDeadTime;
                    end else if (req_l) begin
                        state_d = ST_DEAD_L;
                        cnt_d   = iDeadTime;
                    end
                end
                ST_DEAD_H: begin
                    // A withdrawn or swapped request beats expiry on the same edge.
                    if (!iActive) begin
                        state_d = ST_OFF;
                    end else if (req_l) begin
                        state_d = ST_DEAD_L;
                        cnt_d   = iDeadTime;
                    end else if (cnt_q == '0) begin
                        state_d = ST_HIGH;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_DEAD_L: begin
                    if (!iActive) begin
                        state_d = ST_OFF;
                    end else if (req_h) begin
                        state_d = ST_DEAD_H;
                        cnt_d   = iDeadTime;
                    end else if (cnt_q == '0) begin
                        state_d = ST_LOW;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (req_l) begin
                        state_d = ST_DEAD_L;
                        cnt_d   = iDeadTime;
                    end else if (!iActive) begin
                        state_d = ST_OFF;
                    end
                end
                ST_LOW: begin
                    if (req_h) begin
                        state_d = ST_DEAD_H;
                        cnt_d   = iDeadTime;
                    end else if (!iActive) begin
                        state_d = ST_OFF;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
        high_d = (state_d == ST_HIGH);
        low_d  = (state_d == ST_LOW);
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            high_q  <= 1'b0;
            low_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            high_q  <= high_d;
            low_q   <= low_d;
        end
    end

    assign oHigh = high_q;
    assign oLow  = low_q;

endmodule

// File: rtl/mbldcm_dead_time.sv
// Multi-channel BLDC dead-time generator. Optional fault latch with input
// synchroniser is built only when MBLDCM_DEAD_TIME_FAULT_EN is defined.
module mbldcm_dead_time
    import mbldcm_pkg::*;
#(
    parameter int pNumChannels = 3,
    parameter int pWidthDelay  = 8
) (
    input  logic                    iClock,
    input  logic                    iReset_n,
    input  logic [pWidthDelay-1:0]  iDeadTime,
    input  logic [pNumChannels-1:0] iActive,
    input  logic [pNumChannels-1:0] iPhase,
    input  logic                    iFault_n,
    input  logic                    iFaultClear,
    output logic [pNumChannels-1:0] oHigh,
    output logic [pNumChannels-1:0] oLow,
    output logic                    oFault
);

    logic force_off;

`ifdef MBLDCM_DEAD_TIME_FAULT_EN
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic fault_q, fault_d;

    // A synchronised fault outranks a clear arriving on the same edge.
    always_comb begin
        sync1_d = iFault_n;
        sync2_d = sync1_q;
        fault_d = !sync2_q ? 1'b1 : (fault_q & ~iFaultClear);
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            fault_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            fault_q <= fault_d;
        end
    end

    // Gates drop on the same edge the latch sets, not one cycle later.
    assign force_off = fault_d;
    assign oFault    = fault_q;
`else
    logic unused_fault_in;
    assign unused_fault_in = iFault_n ^ iFaultClear;
    assign force_off       = 1'b0;
    assign oFault          = 1'b0;
`endif

    for (genvar g = 0; g < pNumChannels; g++) begin : g_ch
        mbldcm_dead_time_ch #(
            .pWidthDelay(pWidthDelay)
        ) u_ch (
            .iClock   (iClock),
            .iReset_n (iReset_n),
            .iForceOff(force_off),
            .iDeadTime(iDeadTime),
            .iActive  (iActive[g]),
            .iPhase   (iPhase[g]),
            .oHigh    (oHigh[g]),
            .oLow     (oLow[g])
        );
    end

endmodule

// File: tb/tb_mbldcm_dead_time.sv
// Directed bench for mbldcm_dead_time (3 channels, 8-bit dead time).
module tb_mbldcm_dead_time;

    logic       iClock = 1'b0;
    logic       iReset_n;
    logic [7:0] iDeadTime;
    logic [2:0] iActive;
    logic [2:0] iPhase;
    logic       iFault_n;
    logic       iFaultClear;
    logic [2:0] oHigh;
    logic [2:0] oLow;
    logic       oFault;

    int n_cmp  = 0;
    int n_fail = 0;
    logic overlap_seen = 1'b0;
    logic any_on;

    mbldcm_dead_time #(
        .pNumChannels(3),
        .pWidthDelay (8)
    ) dut (
        .iClock     (iClock),
        .iReset_n   (iReset_n),
        .iDeadTime  (iDeadTime),
        .iActive    (iActive),
        .iPhase     (iPhase),
        .iFault_n   (iFault_n),
        .iFaultClear(iFaultClear),
        .oHigh      (oHigh),
        .oLow       (oLow),
        .oFault     (oFault)
    );

    always #5 iClock = ~iClock;

    always @(negedge iClock) begin
        if (|(oHigh & oLow)) overlap_seen <= 1'b1;
    end

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        iReset_n    = 1'b0;
        iDeadTime   = 8'd3;
        iActive     = 3'b000;
        iPhase      = 3'b000;
        iFault_n    = 1'b1;
        iFaultClear = 1'b0;
        tick();
        tick();
        chk("rst_high", 32'(oHigh), 32'd0);
        chk("rst_low", 32'(oLow), 32'd0);
        chk("rst_fault", 32'(oFault), 32'd0);
        iReset_n = 1'b1;
        tick();
        tick();

        // turn-on from OFF, D=3: rises after edge e+4
        iActive = 3'b001;
        iPhase  = 3'b001;
        repeat (4) tick();
        chk("on_pre", 32'(oHigh), 32'd0);
        tick();
        chk("on_high", 32'(oHigh), 32'b001);
        chk("on_low_idle", 32'(oLow), 32'd0);

        // swap high -> low
        iPhase = 3'b000;
        tick();
        chk("swap_high_drop", 32'(oHigh), 32'd0);
        chk("swap_low_early", 32'(oLow), 32'd0);
        repeat (3) tick();
        chk("swap_low_pre", 32'(oLow), 32'd0);
        tick();
        chk("swap_low_on", 32'(oLow), 32'b001);

        iActive = 3'b000;
        tick();
        chk("off_low", 32'(oLow), 32'd0);

        // D=0, ch1 toggled every cycle: never turns on
        iDeadTime = 8'd0;
        iActive   = 3'b010;
        iPhase    = 3'b000;
        any_on    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            iPhase[1] = ~iPhase[1];
            tick();
            any_on = any_on | oHigh[1] | oLow[1];
        end
        chk("toggle_none", 32'(any_on), 32'd0);
        iPhase[1] = 1'b1;
        tick();
        chk("d0_pre", 32'(oHigh), 32'd0);
        tick();
        chk("d0_on", 32'(oHigh), 32'b010);
        iPhase[1] = 1'b0;
        tick();
        chk("d0_drop", 32'(oHigh | oLow), 32'd0);
        tick();
        chk("d0_low", 32'(oLow), 32'b010);
        iActive = 3'b000;
        tick();

        // D=255 with iDeadTime changed mid-count
        iDeadTime = 8'd255;
        iActive   = 3'b100;
        iPhase    = 3'b100;
        tick();
        iDeadTime = 8'd1;
        repeat (255) tick();
        chk("d255_pre", 32'(oHigh), 32'd0);
        tick();
        chk("d255_on", 32'(oHigh), 32'b100);
        iActive = 3'b000;
        tick();

        // request withdrawn on the expiry edge
        iDeadTime = 8'd2;
        iActive   = 3'b001;
        iPhase    = 3'b001;
        repeat (3) tick();
        iActive = 3'b000;
        tick();
        chk("withdraw_edge", 32'(oHigh), 32'd0);
        tick();
        chk("withdraw_after", 32'(oHigh), 32'd0);

        // all three legs high with D=3
        iDeadTime = 8'd3;
        iActive   = 3'b111;
        iPhase    = 3'b111;
        repeat (5) tick();
        chk("all_high", 32'(oHigh), 32'b111);

        iFault_n = 1'b0;
        tick();
        iFault_n = 1'b1;
`ifdef MBLDCM_DEAD_TIME_FAULT_EN
        tick();
        chk("fault_pre", 32'(oFault), 32'd0);
        chk("fault_pre_gates", 32'(oHigh), 32'b111);
        tick();
        chk("fault_set", 32'(oFault), 32'd1);
        chk("fault_gates", 32'(oHigh | oLow), 32'd0);
        repeat (6) tick();
        chk("fault_hold", 32'(oFault), 32'd1);
        chk("fault_hold_gates", 32'(oHigh | oLow), 32'd0);
        iFaultClear = 1'b1;
        tick();
        iFaultClear = 1'b0;
        chk("fault_clear", 32'(oFault), 32'd0);
        repeat (3) tick();
        chk("restart_pre", 32'(oHigh), 32'd0);
        tick();
        chk("restart_on", 32'(oHigh), 32'b111);
`else
        repeat (4) tick();
        chk("nofault_flag", 32'(oFault), 32'd0);
        chk("nofault_gates", 32'(oHigh), 32'b111);
`endif

        // async reset mid-cycle while gates are high
        #3;
        iReset_n = 1'b0;
        #1;
        chk("arst_high", 32'(oHigh), 32'd0);
        chk("arst_low", 32'(oLow), 32'd0);
        chk("arst_fault", 32'(oFault), 32'd0);
        iPhase   = 3'b000;
        iReset_n = 1'b1;
        tick();
        repeat (3) tick();
        chk("post_rst_pre", 32'(oLow), 32'd0);
        tick();
        chk("post_rst_on", 32'(oLow), 32'b111);

        iActive = 3'b000;
        tick();
        chk("never_overlap", 32'(overlap_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mbldcm_dead_time.md
# mbldcm_dead_time

Multi-channel dead-time generator for the BLDC half-bridge gate drive, and the parametrised successor of the single-signal on-delay block. Each channel turns a per-phase command (active, high/low select) into complementary high-side and low-side gate enables. A runtime-programmable dead interval separates the two, so both switches of a leg are never on together. The block sits between the commutation logic and the gate-driver pins.

## Interface
- pNumChannels, 3, number of half-bridge legs (≥1)
- pWidthDelay, 8, width of the dead-time count (≥1)

- iClock  in  1  system clock
- iReset_n  in  1  reset; asynchronous and active-low
- iDeadTime  in  pWidthDelay  dead-time setting D; dead interval = D+1 cycles
- iActive  in  pNumChannels  per-channel drive request; 0 requests both switches off
- iPhase  in  pNumChannels  per-channel side select; 1 = high side, 0 = low side; ignored when iActive=0
- iFault_n  in  1  external fault, active-low (used only with the fault macro)
- iFaultClear  in  1  fault-latch clear pulse (used only with the fault macro)
- oHigh  out  pNumChannels  high-side gate enable, registered
- oLow  out  pNumChannels  low-side gate enable, registered
- oFault  out  1  latched fault flag, registered

## Operation
- Per-channel request decode: REQ_H = iActive & iPhase; REQ_L = iActive & ~iPhase; REQ_OFF = ~iActive.
- Per-channel FSM states: OFF, DEAD_H, HIGH, DEAD_L, LOW. Reset state is OFF.
- Dead counter:
  - Down-counter of pWidthDelay bits.
  - Loaded with iDeadTime on every entry into DEAD_H or DEAD_L, including re-entry.
  - Decrements while in a dead state and cnt≠0; never wraps.
- Transitions, evaluated every edge, request checked before expiry:
  - OFF: REQ_H→DEAD_H; REQ_L→DEAD_L; else stay.
  - DEAD_H: REQ_OFF→OFF; REQ_L→DEAD_L (reload); REQ_H and cnt==0→HIGH; else stay.
  - DEAD_L: mirror of DEAD_H.
  - HIGH: REQ_L→DEAD_L; REQ_OFF→OFF; else stay.
  - LOW: REQ_H→DEAD_H; REQ_OFF→OFF; else stay.
- Outputs: oHigh is a flop set only on the transition into HIGH; oLow only into LOW. Both are cleared on any exit.
- iDeadTime is sampled only at dead-state entry. Changing it mid-count does not affect a count in progress.
- Channels are fully independent and share only iDeadTime and the fault latch.

## Timing
- Reset: asynchronous assertion forces every channel to OFF and sets oHigh=0, oLow=0, oFault=0 and all counters to 0 immediately, without waiting for a clock edge. Release is synchronous to the next iClock edge.
- Turn-on: request first sampled at edge e (from OFF or the opposite on-state). The gate rises after edge e+D+1.
- Turn-off: a request change sampled at edge e drops the active gate after edge e. Latency is 1 cycle.
- Guaranteed both-low window on a side swap: ≥ D+1 cycles. D=0 gives 1 cycle.
- D = 2^pWidthDelay−1: no overflow, since the counter only counts down.
- Request toggles during a dead state restart the count. No gate asserts until a full D+1 window passes with a stable request.
- Request withdrawn on the same edge that cnt reaches 0: the request wins and the gate does not assert.
- oHigh[i] & oLow[i] is never 1 in any cycle.

## Configuration
- MBLDCM_DEAD_TIME_FAULT_EN defined:
  - iFault_n is synchronised through 2 flops.
  - A synchronised low sets rFault. oFault rises 3 edges after iFault_n falls.
  - While rFault=1, all channels are forced to OFF and oHigh and oLow stay 0; fault takes priority over requests and dead counting.
  - rFault clears on an iClock edge where iFaultClear=1 and the synchronised iFault_n=1. The next request restarts a full dead interval from OFF.
- MBLDCM_DEAD_TIME_FAULT_EN not defined:
  - iFault_n and iFaultClear ports remain but are ignored.
  - oFault is constant 0; no synchroniser or latch is built.

## Structure
- Shared package mbldcm_pkg holds:
  - FSM state encodings: OFF, DEAD_H, HIGH, DEAD_L, LOW.
  - The clog2 width helper.
- One sub-module, mbldcm_dead_time_ch: a single channel (FSM, counter, output flops) with a force-off input driven by the fault latch.
- The top module generates pNumChannels instances and owns the fault synchroniser and latch.

## Test plan
- D=3, ch0 iActive=1, iPhase=1 from reset idle, request sampled edge 10 -> oHigh[0] rises after edge 14; oLow[0] stays 0.
- ch0 HIGH, iPhase 1→0 sampled edge 20, D=3 -> oHigh[0] falls after edge 20; oLow[0] rises after edge 24; 4 cycles both low.
- D=0, iPhase toggled every cycle -> neither gate ever asserts; with iPhase held 2 cycles the gate asserts for 1 cycle; oHigh&oLow never 1.
- D=255 (pWidthDelay=8), iDeadTime changed to 1 mid-count -> gate rises exactly 256 cycles after the request; no wrap.
- Iteration A, FAULT_EN, ch0–2 driving: iFault_n low for 1 cycle -> oFault=1 within 3 edges and all gates 0; with iFaultClear held low, gates stay 0 even after iFault_n returns high.
- Iteration B, FAULT_EN: starting from the latched fault of iteration A, pulse iFaultClear with iFault_n high -> oFault clears; gates restart after D+1 cycles.
- iReset_n asserted mid-count between edges -> all outputs 0 before the next edge; after release, the request needs a full D+1 window.
